// File: rtl/tdc_fine_cal.sv
// rtl/tdc_fine_cal.sv - thermometer-code fine-count calculator with bubble detect and valid/ready result port
module tdc_fine_cal #(
    parameter int CODE_W = 16,
    parameter int SLICE  = 4,
    parameter int OFFSET = 1,
    localparam int RES_W = $clog2(CODE_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code,
    input  logic              mode,
    input  logic              load,
    output logic              busy,
    output logic              drop,
    output logic [RES_W-1:0]  res,
    output logic              bubble,
    output logic              sat,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int N    = CODE_W / SLICE;
    localparam int SC_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    state_t             state_nxt;

    logic [CODE_W-1:0]  sreg;
    logic               mode_q;
    logic               seen_zero;
    logic               bub_acc;
    logic [RES_W-1:0]   raw;
    logic [SC_W-1:0]    slice_cnt;

    logic [RES_W-1:0]   res_q;
    logic               bubble_q;
    logic               sat_q;
    logic               drop_q;

    logic               accept;
    logic               reject;
    logic               last_slice;

    logic               sz_n;
    logic               bub_n;
    logic [RES_W-1:0]   raw_n;
    logic [RES_W:0]     diff;

    // One slice of the scan; seen_zero ripples through the slice so
    // later bits see zeros from earlier bits of the same cycle.
    always_comb begin
        sz_n  = seen_zero;
        bub_n = bub_acc;
        raw_n = raw;
        for (int i = 0; i < SLICE; i++) begin
            if (sreg[i] && sz_n) begin
                bub_n = 1'b1;
            end
            if (sreg[i] && (!mode_q || !sz_n)) begin
                raw_n = raw_n + RES_W'(1);
            end
            if (!sreg[i]) begin
                sz_n = 1'b1;
            end
        end
        diff = {1'b0, raw_n} - (RES_W + 1)'(OFFSET);
    end

    always_comb begin
        accept     = load && ((state == IDLE) || ((state == DONE) && out_ready));
        reject     = load && !accept;
        last_slice = (state == SHIFT) && (slice_cnt == SC_W'(N - 1));
        state_nxt  = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_slice) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = load ? SHIFT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg      <= '0;
            mode_q    <= 1'b0;
            seen_zero <= 1'b0;
            bub_acc   <= 1'b0;
            raw       <= '0;
            slice_cnt <= '0;
            res_q     <= '0;
            bubble_q  <= 1'b0;
            sat_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= reject;
            if (accept) begin
                sreg      <= code;
                mode_q    <= mode;
                seen_zero <= 1'b0;
                bub_acc   <= 1'b0;
                raw       <= '0;
                slice_cnt <= '0;
            end else if (state == SHIFT) begin
                sreg      <= sreg >> SLICE;
                seen_zero <= sz_n;
                bub_acc   <= bub_n;
                raw       <= raw_n;
                slice_cnt <= slice_cnt + SC_W'(1);
            end
            // Result registers hold for all of DONE and clear once consumed.
            if (last_slice) begin
                res_q    <= diff[RES_W] ? '0 : diff[RES_W-1:0];
                sat_q    <= diff[RES_W];
                bubble_q <= bub_n;
            end else if ((state == DONE) && out_ready) begin
                res_q    <= '0;
                sat_q    <= 1'b0;
                bubble_q <= 1'b0;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign drop      = drop_q;
    assign res       = res_q;
    assign bubble    = bubble_q;
    assign sat       = sat_q;

endmodule

// File: doc/tdc_fine_cal.md
# tdc_fine_cal

Parametrised fine-code calculator for the TDC datapath. It captures a CODE_W-bit thermometer code from the delay line and scans it SLICE bits per cycle. It produces either the total ones count or the unbroken run of ones from bit 0, minus a fixed OFFSET, saturating at zero, along with a bubble-error flag. Results leave through a valid/ready output handshake towards the timestamp assembler, so back-pressure no longer loses data.

## Interface
- CODE_W, 16: thermometer code width; ≥2.
- SLICE, 4: bits consumed per scan cycle; must divide CODE_W.
- OFFSET, 1: constant subtracted from the raw count.
- RES_W, $clog2(CODE_W+1): result width (derived; do not override).

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- code  in  CODE_W  thermometer code; sampled only on an accepted load.
- mode  in  1  0 = popcount, 1 = leading-run count; sampled with code.
- load  in  1  request to capture code/mode.
- busy  out  1  high in SHIFT and DONE.
- drop  out  1  one-cycle pulse when a load is rejected.
- res  out  RES_W  result, valid while out_valid.
- bubble  out  1  code contained a 1 above a 0; valid while out_valid.
- sat  out  1  raw count < OFFSET, res clamped to 0; valid while out_valid.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.

## Operation
- States: IDLE, SHIFT, DONE. Reset: state IDLE. All outputs 0: busy, drop, res, bubble, sat, out_valid. Internal shift register, counters and flags are also 0.
- Load acceptance. A load is accepted when state is IDLE, or when state is DONE and out_ready=1 in the same cycle (back-to-back).
  - On accept: shift register ← code, mode latched, raw count ← 0, seen_zero ← 0, bubble ← 0, slice counter ← 0. Next state is SHIFT.
- Load rejection. A load in SHIFT, or in DONE with out_ready=0, is ignored and drop pulses high for the following cycle. The in-flight computation is unaffected.
- SHIFT, per cycle: process bits [SLICE-1:0] of the shift register in order from LSB upward, then shift right by SLICE.
  - For each bit b: if b=1 and seen_zero=1, set bubble.
  - If b=0, set seen_zero (this takes effect for later bits in the same slice).
  - mode 0: raw += b.
  - mode 1: raw += b only while seen_zero is still 0, where seen_zero includes the effect of earlier bits in this slice.
- After CODE_W/SLICE SHIFT cycles, the next state is DONE.
  - On DONE entry: res ← (raw ≥ OFFSET) ? raw−OFFSET : 0, and sat ← (raw < OFFSET).
  - res, bubble and sat are registered and stay stable for the whole of DONE.
- DONE: out_valid=1.
  - If out_ready=1 and no load: next state IDLE; out_valid, res, bubble and sat drop to 0.
  - If out_ready=1 with load: accept the new code as above.
- Raw count never exceeds CODE_W; RES_W holds it without wrap. The subtraction is done at RES_W+1 bits to detect underflow.
- rst in any state aborts the computation immediately and returns to reset values. No partial result is emitted.

## Timing
- Accepted load at edge k puts the block in SHIFT on cycles k+1 … k+N, where N = CODE_W/SLICE.
- out_valid rises at edge k+N+1. Load-to-valid latency is N+1 cycles (5 with the defaults).
- busy is high from k+1 until the cycle after the result is accepted.
- Throughput with out_ready tied high and back-to-back loads: one result per N+1 cycles.
- drop asserts exactly one cycle after the rejected load cycle. Consecutive rejected loads give consecutive drop pulses.
- out_valid never deasserts without out_ready=1. res, bubble and sat never change while out_valid=1 and out_ready=0.

## Test plan
- Defaults; code=16'h00FF, mode=0, out_ready=1 → out_valid exactly 5 cycles after load; res=7, bubble=0, sat=0; then IDLE.
- code=16'h0F0F. mode=0 → res=7, bubble=1. mode=1 → res=3, bubble=1.
- code=16'h0000, mode=0 → res=0, sat=1, bubble=0. code=16'hFFFF, mode=1 → res=15, sat=0.
- Back-pressure: hold out_ready=0 for 4 cycles in DONE → res/flags stable, out_valid held. A load in that window → drop pulse, result unchanged. Then out_ready=1 together with a load of 16'h0003 → new result res=1 after 5 more cycles.
- Load pulse during SHIFT → drop=1 the next cycle, original result correct. Assert rst during SHIFT cycle 2 → all outputs 0 next cycle, no out_valid afterwards.
- SLICE=1 and SLICE=16 builds with code=16'h7FFF, mode=1 → res=14. Latency is 17 and 2 cycles respectively.
